id_regfile_sb: RTL and testbench
================================

# id_regfile_sb

Parametrised register file for the decode stage with two combinational read ports, one writeback port, same-cycle write-to-read bypass and a per-register busy scoreboard. Decode presents its source and destination selects each cycle. The block returns operands, raises Stall on read-after-write or write-after-write hazards against outstanding writes, and tracks the number of outstanding destinations. Writeback drives the write port, which updates the array and retires the busy bit.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥ 2); AW = clog2(DEPTH)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to matching read ports

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReadSelect1  in  AW  source 1 register index
- ReadSelect2  in  AW  source 2 register index
- ReadUse1  in  1  source 1 is consumed by the decoding instruction
- ReadUse2  in  1  source 2 is consumed by the decoding instruction
- ReadData1  out  WIDTH  source 1 operand (combinational)
- ReadData2  out  WIDTH  source 2 operand (combinational)
- WriteData  in  WIDTH  writeback data
- WriteSelect  in  AW  writeback register index
- WriteEnable  in  1  writeback valid
- IssueValid  in  1  decode is presenting an instruction
- IssueWrites  in  1  instruction writes a destination register
- IssueDest  in  AW  destination register index
- Stall  out  1  hazard, instruction not issued this cycle (combinational)
- BusyCount  out  clog2(DEPTH+1)  number of busy registers (registered)

## Operation
- Storage: DEPTH x WIDTH array plus DEPTH busy bits.
- Zero register: with ZERO_REG=1, index 0 is never written, never set busy, and always reads 0.
- Read path: ReadDataN = array[ReadSelectN]. With BYPASS=1, if WriteEnable and WriteSelect==ReadSelectN (and the index is not zero-masked), ReadDataN = WriteData.
- Writeback clear: wclr[i] = WriteEnable && WriteSelect==i, masked for index 0 when ZERO_REG=1.
- Effective busy: ebusy[i] = busy[i] && !(BYPASS && wclr[i]). With BYPASS=0 a register in writeback still counts as busy this cycle.
- Stall = IssueValid && ((ReadUse1 && ebusy[ReadSelect1]) || (ReadUse2 && ebusy[ReadSelect2]) || (IssueWrites && ebusy[IssueDest])). This is RAW plus WAW protection; one outstanding write per register.
- Issue accept: acc = IssueValid && !Stall && IssueWrites && the destination is not zero-masked.
- Busy update per register: set on acc to that index, clear on wclr.
  - Simultaneous set and clear on the same index leaves the bit set (set wins).
- Array write: on WriteEnable, array[WriteSelect] <= WriteData.
  - A writeback to a non-busy register is legal; the data is written and busy stays 0.
- BusyCount: next = BusyCount + (set applied to a bit that was 0) − (clear applied to a bit that was 1 and not re-set). It is always equal to the popcount of the busy bits.

## Timing
- Reset_n low, asynchronous: all array entries = 0, all busy = 0, BusyCount = 0. Stall is 0 while IssueValid = 0.
- Reset_n deasserts asynchronously; the first state update occurs at the next rising Clk edge after Reset_n is high.
- Reset mid-operation discards all outstanding busy bits; a later writeback to such a register is treated as a non-busy write.
- Read latency is 0 cycles (combinational from selects, and from the write port when bypassing).
- A written value is visible from the array in the cycle after the write edge. With BYPASS=1 it is also visible in the write cycle itself.
- Busy set by an accepted issue at edge N:
  - A dependent read stalls from cycle N+1.
  - The dependency releases in the writeback cycle with BYPASS=1, or the cycle after writeback with BYPASS=0.
- BusyCount reflects busy bits after the same edge, with 1-cycle latency from acc or wclr.
- Stall depends only on current inputs and registered busy bits; no combinational path from Stall back to any input is required.

## Test plan
- Reset: write 0xDEADBEEF to r5 and issue r7, then pulse Reset_n low mid-cycle -> ReadData1(r5)=0 immediately, BusyCount=0, Stall=0 with ReadUse1 on r7.
- RAW: issue dest r3, next cycle read r3 with ReadUse1=1 -> Stall=1 and BusyCount=1. Writeback r3=0x12345678 with BYPASS=1 -> same cycle Stall=0 and ReadData1=0x12345678; next cycle BusyCount=0.
- WAW: issue dest r9 twice on consecutive cycles -> second Stall=1 and BusyCount remains 1. After writeback r9, re-issue is accepted and BusyCount returns to 1.
- Simultaneous: writeback r4 and issue dest r4 in the same cycle with r4 busy -> Stall=0 and r4 busy afterwards (set wins), BusyCount unchanged; array r4 holds the writeback data.
- Zero register: issue dest r0, write 0xFFFFFFFF to r0, read r0 on both ports -> ReadData=0, Stall=0, BusyCount=0.
- BYPASS=0 instance: writeback r2=0xA5A5A5A5 while reading r2 busy -> Stall=1 and ReadData1=old value that cycle; next cycle Stall=0 and ReadData1=0xA5A5A5A5.

Source files
------------

// File: rtl/id_regfile_sb_if.sv
// Decode/writeback bundle for id_regfile_sb: read ports, write port, issue request and status.
interface id_regfile_sb_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) ();
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    ReadSelect1;
  logic [AW-1:0]    ReadSelect2;
  logic             ReadUse1;
  logic             ReadUse2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [WIDTH-1:0] WriteData;
  logic [AW-1:0]    WriteSelect;
  logic             WriteEnable;
  logic             IssueValid;
  logic             IssueWrites;
  logic [AW-1:0]    IssueDest;
  logic             Stall;
  logic [CW-1:0]    BusyCount;

  modport master (
    output ReadSelect1, ReadSelect2, ReadUse1, ReadUse2,
    output WriteData, WriteSelect, WriteEnable,
    output IssueValid, IssueWrites, IssueDest,
    input  ReadData1, ReadData2, Stall, BusyCount
  );

  modport slave (
    input  ReadSelect1, ReadSelect2, ReadUse1, ReadUse2,
    input  WriteData, WriteSelect, WriteEnable,
    input  IssueValid, IssueWrites, IssueDest,
    output ReadData1, ReadData2, Stall, BusyCount
  );
endinterface

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with write-to-read bypass and a per-register busy scoreboard
// that stalls RAW/WAW hazards against outstanding writebacks.
module id_regfile_sb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset_n,
  id_regfile_sb_if.slave rf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DEPTH-1:0] wclr, ebusy, set_vec;
  logic             stall, acc, inc, dec;
  logic             wr_ok;

  // Writes to a zero-masked index are dropped entirely.
  assign wr_ok = rf.WriteEnable && !(ZERO_REG && (rf.WriteSelect == '0));

  always_comb begin
    wclr    = '0;
    set_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wclr[i] = wr_ok && (rf.WriteSelect == AW'(i));
    end
    ebusy = BYPASS ? (busy_q & ~wclr) : busy_q;
    stall = rf.IssueValid && ((rf.ReadUse1 && ebusy[rf.ReadSelect1]) ||
                              (rf.ReadUse2 && ebusy[rf.ReadSelect2]) ||
                              (rf.IssueWrites && ebusy[rf.IssueDest]));
    acc   = rf.IssueValid && !stall && rf.IssueWrites &&
            !(ZERO_REG && (rf.IssueDest == '0));
    for (int i = 0; i < DEPTH; i++) begin
      set_vec[i] = acc && (rf.IssueDest == AW'(i));
    end
    // Set wins over a same-cycle clear on the same index.
    busy_d = (busy_q & ~wclr) | set_vec;
    inc    = |(set_vec & ~busy_q);
    dec    = |(wclr & busy_q & ~set_vec);
    cnt_d  = cnt_q + CW'(inc) - CW'(dec);
  end

  always_comb begin
    rf.ReadData1 = mem_q[rf.ReadSelect1];
    if (ZERO_REG && (rf.ReadSelect1 == '0)) begin
      rf.ReadData1 = '0;
    end else if (BYPASS && wr_ok && (rf.WriteSelect == rf.ReadSelect1)) begin
      rf.ReadData1 = rf.WriteData;
    end
  end

  always_comb begin
    rf.ReadData2 = mem_q[rf.ReadSelect2];
    if (ZERO_REG && (rf.ReadSelect2 == '0)) begin
      rf.ReadData2 = '0;
    end else if (BYPASS && wr_ok && (rf.WriteSelect == rf.ReadSelect2)) begin
      rf.ReadData2 = rf.WriteData;
    end
  end

  assign rf.Stall     = stall;
  assign rf.BusyCount = cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[rf.WriteSelect] <= rf.WriteData;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: vector table over a bypassing and a non-bypassing instance,
// plus a hand-written asynchronous reset sequence.
module tb_id_regfile_sb;
  logic clk;
  logic rst_n;

  id_regfile_sb_if #(.WIDTH(32), .DEPTH(32)) ifa ();
  id_regfile_sb_if #(.WIDTH(32), .DEPTH(32)) ifb ();

  id_regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .Clk     (clk),
    .Reset_n (rst_n),
    .rf      (ifa)
  );

  id_regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .Clk     (clk),
    .Reset_n (rst_n),
    .rf      (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          dut;
    logic [4:0]  rs1, rs2;
    bit          u1, u2, we;
    logic [4:0]  ws;
    logic [31:0] wd;
    bit          iv, iw;
    logic [4:0]  id;
    logic [31:0] e_rd1, e_rd2;
    bit          e_st;
    logic [5:0]  e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rd1, rd2;
    bit          st;
    logic [5:0]  cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(bit dut, logic [4:0] rs1, logic [4:0] rs2, bit u1, bit u2,
                              bit we, logic [4:0] ws, logic [31:0] wd, bit iv, bit iw,
                              logic [4:0] id, logic [31:0] e_rd1, logic [31:0] e_rd2,
                              bit e_st, logic [5:0] e_cnt);
    vec_t v;
    v.dut = dut; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.we = we; v.ws = ws; v.wd = wd; v.iv = iv; v.iw = iw; v.id = id;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_st = e_st; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic idle_all();
    ifa.ReadSelect1 = '0; ifa.ReadSelect2 = '0; ifa.ReadUse1 = 0; ifa.ReadUse2 = 0;
    ifa.WriteEnable = 0; ifa.WriteSelect = '0; ifa.WriteData = '0;
    ifa.IssueValid = 0; ifa.IssueWrites = 0; ifa.IssueDest = '0;
    ifb.ReadSelect1 = '0; ifb.ReadSelect2 = '0; ifb.ReadUse1 = 0; ifb.ReadUse2 = 0;
    ifb.WriteEnable = 0; ifb.WriteSelect = '0; ifb.WriteData = '0;
    ifb.IssueValid = 0; ifb.IssueWrites = 0; ifb.IssueDest = '0;
  endtask

  task automatic drive(vec_t v);
    idle_all();
    if (!v.dut) begin
      ifa.ReadSelect1 = v.rs1; ifa.ReadSelect2 = v.rs2; ifa.ReadUse1 = v.u1; ifa.ReadUse2 = v.u2;
      ifa.WriteEnable = v.we; ifa.WriteSelect = v.ws; ifa.WriteData = v.wd;
      ifa.IssueValid = v.iv; ifa.IssueWrites = v.iw; ifa.IssueDest = v.id;
    end else begin
      ifb.ReadSelect1 = v.rs1; ifb.ReadSelect2 = v.rs2; ifb.ReadUse1 = v.u1; ifb.ReadUse2 = v.u2;
      ifb.WriteEnable = v.we; ifb.WriteSelect = v.ws; ifb.WriteData = v.wd;
      ifb.IssueValid = v.iv; ifb.IssueWrites = v.iw; ifb.IssueDest = v.id;
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    idle_all();
    rst_n = 1'b0;

    // Bypassing instance: reset state, RAW, WAW, set-wins, zero register, plain writes.
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        0, 0,  0, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1,  3, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  3, 0, 1, 0, 0,  0, 32'h0,        1, 0,  0, 32'h0,        32'h0,   1, 1));
    vecs.push_back(mk(0,  3, 0, 1, 0, 1,  3, 32'h12345678, 1, 0,  0, 32'h12345678, 32'h0,   0, 1));
    vecs.push_back(mk(0,  3, 0, 0, 0, 0,  0, 32'h0,        0, 0,  0, 32'h12345678, 32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1,  9, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1,  9, 32'h0,        32'h0,   1, 1));
    vecs.push_back(mk(0,  9, 0, 0, 0, 0,  0, 32'h0,        0, 0,  0, 32'h0,        32'h0,   0, 1));
    vecs.push_back(mk(0,  9, 0, 0, 0, 1,  9, 32'h99,       0, 0,  0, 32'h99,       32'h0,   0, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1,  9, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  9, 0, 0, 0, 0,  0, 32'h0,        0, 0,  0, 32'h99,       32'h0,   0, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1,  4, 32'h0,        32'h0,   0, 1));
    vecs.push_back(mk(0,  4, 0, 0, 0, 1,  4, 32'hCAFE0004, 1, 1,  4, 32'hCAFE0004, 32'h0,   0, 2));
    vecs.push_back(mk(0,  4, 0, 1, 0, 0,  0, 32'h0,        1, 0,  0, 32'hCAFE0004, 32'h0,   1, 2));
    vecs.push_back(mk(0,  4, 0, 0, 0, 1,  4, 32'h44,       0, 0,  0, 32'h44,       32'h0,   0, 2));
    vecs.push_back(mk(0,  0, 9, 0, 0, 1,  9, 32'h999,      0, 0,  0, 32'h0,        32'h999, 0, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1,  0, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 1, 1, 1,  0, 32'hFFFFFFFF, 1, 0,  0, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 1, 1, 0,  0, 32'h0,        1, 1,  0, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 0, 0, 1,  7, 32'h77,       0, 0,  0, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0,  7, 0, 1, 0, 0,  0, 32'h0,        1, 0,  0, 32'h77,       32'h0,   0, 0));
    vecs.push_back(mk(0,  0, 0, 0, 0, 0,  0, 32'h0,        1, 1, 12, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(0, 12,12, 0, 1, 0,  0, 32'h0,        1, 0,  0, 32'h0,        32'h0,   1, 1));
    vecs.push_back(mk(0, 12, 0, 0, 0, 0,  0, 32'h0,        1, 0,  0, 32'h0,        32'h0,   0, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0, 1, 12, 32'hC,        0, 0,  0, 32'h0,        32'h0,   0, 1));
    vecs.push_back(mk(0, 12, 0, 0, 0, 0,  0, 32'h0,        0, 0,  0, 32'hC,        32'h0,   0, 0));
    // Non-bypassing instance: writeback does not release the hazard until the next cycle.
    vecs.push_back(mk(1,  2, 0, 0, 0, 1,  2, 32'h11111111, 0, 0,  0, 32'h0,        32'h0,   0, 0));
    vecs.push_back(mk(1,  2, 0, 0, 0, 0,  0, 32'h0,        1, 1,  2, 32'h11111111, 32'h0,   0, 0));
    vecs.push_back(mk(1,  2, 0, 1, 0, 1,  2, 32'hA5A5A5A5, 1, 0,  0, 32'h11111111, 32'h0,   1, 1));
    vecs.push_back(mk(1,  2, 0, 1, 0, 0,  0, 32'h0,        1, 0,  0, 32'hA5A5A5A5, 32'h0,   0, 0));

    #12 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      drive(v);
      e.idx = i; e.rd1 = v.e_rd1; e.rd2 = v.e_rd2; e.st = v.e_st; e.cnt = v.e_cnt;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      if (!v.dut) begin
        check($sformatf("v%0d ReadData1", e.idx), ifa.ReadData1, e.rd1);
        check($sformatf("v%0d ReadData2", e.idx), ifa.ReadData2, e.rd2);
        check($sformatf("v%0d Stall", e.idx), 32'(ifa.Stall), 32'(e.st));
        check($sformatf("v%0d BusyCount", e.idx), 32'(ifa.BusyCount), 32'(e.cnt));
      end else begin
        check($sformatf("v%0d ReadData1", e.idx), ifb.ReadData1, e.rd1);
        check($sformatf("v%0d ReadData2", e.idx), ifb.ReadData2, e.rd2);
        check($sformatf("v%0d Stall", e.idx), 32'(ifb.Stall), 32'(e.st));
        check($sformatf("v%0d BusyCount", e.idx), 32'(ifb.BusyCount), 32'(e.cnt));
      end
    end

    // Asynchronous reset mid-operation discards data and outstanding busy bits.
    @(negedge clk);
    idle_all();
    ifa.WriteEnable = 1; ifa.WriteSelect = 5'd5; ifa.WriteData = 32'hDEADBEEF;
    ifa.IssueValid = 1; ifa.IssueWrites = 1; ifa.IssueDest = 5'd7;
    #2 check("rst pre issue Stall", 32'(ifa.Stall), 32'd0);
    @(negedge clk);
    idle_all();
    ifa.ReadSelect1 = 5'd5;
    #2;
    check("rst pre ReadData1 r5", ifa.ReadData1, 32'hDEADBEEF);
    check("rst pre BusyCount", 32'(ifa.BusyCount), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst ReadData1 r5", ifa.ReadData1, 32'h0);
    check("rst BusyCount", 32'(ifa.BusyCount), 32'd0);
    ifa.IssueValid = 1; ifa.ReadUse1 = 1; ifa.ReadSelect1 = 5'd7;
    #1 check("rst Stall r7", 32'(ifa.Stall), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("post rst Stall r7", 32'(ifa.Stall), 32'd0);
    check("post rst BusyCount", 32'(ifa.BusyCount), 32'd0);
    idle_all();
    ifa.WriteEnable = 1; ifa.WriteSelect = 5'd7; ifa.WriteData = 32'h7;
    @(negedge clk);
    idle_all();
    ifa.ReadSelect1 = 5'd7;
    #2;
    check("post rst ReadData1 r7", ifa.ReadData1, 32'h7);
    check("post rst write BusyCount", 32'(ifa.BusyCount), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
